riscv_dmem_ctrl: RTL and testbench
==================================

Name: riscv_dmem_ctrl

Overview:
- Sequences data-memory accesses issued by the EX stage onto a single-outstanding request/acknowledge data bus.
- Generates byte enables and store-data lane replication, and aligns and sign/zero-extends load data.
- Raises misaligned and access-fault exceptions.
- Drives the pipeline stall that freezes the EX/MEM/WB pipeline registers while an access is in flight.

Parameters:
- XLEN, 32, data/address width; only 32 is supported, any other value is an elaboration error.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- flush  input  1  pipeline flush (any MEM/WB exception or branch kill)
- ex_req  input  1  EX holds a load/store
- ex_bubble  input  1  EX instruction is a bubble; suppresses ex_req
- ex_we  input  1  1 = store, 0 = load
- ex_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_adr  input  XLEN  byte address
- ex_d  input  XLEN  store data, right-aligned
- dmem_stall  output  1  freeze pipeline
- mem_q  output  XLEN  aligned, extended load result
- mem_q_valid  output  1  one-cycle load-complete strobe
- ma_load  output  1  misaligned load exception strobe
- ma_store  output  1  misaligned store exception strobe
- ac_fault  output  1  bus access fault strobe
- mem_badaddr  output  XLEN  faulting address
- dbus_req  output  1  bus request, held until ack/err
- dbus_we  output  1  bus write
- dbus_adr  output  XLEN  word-aligned address (low 2 bits forced 0)
- dbus_be  output  4  byte enables
- dbus_d  output  XLEN  lane-replicated write data
- dbus_ack  input  1  transfer complete
- dbus_err  input  1  transfer error (terminates like ack)
- dbus_q  input  XLEN  read data, valid with ack

Behaviour:
- Reset: state IDLE. dbus_req, dbus_we, mem_q_valid, ma_load, ma_store, ac_fault = 0. dbus_adr, dbus_be, dbus_d, mem_q, mem_badaddr = 0.
- States: IDLE, BUSY, DRAIN, DONE. All outputs except dmem_stall are registered.
- accept = state==IDLE & ex_req & !ex_bubble & !flush.
- Misalignment: H/HU with adr[0]=1, or W with adr[1:0]!=0.
- IDLE, accept & misaligned:
  - No bus cycle.
  - Next cycle: ma_load (ex_we=0) or ma_store (ex_we=1) pulses for one cycle, mem_badaddr=ex_adr.
  - State -> DONE.
- IDLE, accept & aligned:
  - Next cycle: dbus_req=1 with dbus_we/adr/be/d loaded; state -> BUSY. Size and adr[1:0] captured for load alignment.
- Byte enables (k = adr[1:0]):
  - B: 0001<<k
  - H: 0011<<k
  - W: 1111
- Store data replication:
  - B: {4{d[7:0]}}
  - H: {2{d[15:0]}}
  - W: d
- BUSY:
  - dbus_req and all bus outputs held stable until dbus_ack|dbus_err.
  - On ack: dbus_req=0 next cycle, state -> DONE. For loads, mem_q = (dbus_q >> 8k) truncated to size and sign-extended (B/H) or zero-extended (BU/HU/W); mem_q_valid=1 for one cycle.
  - On err: ac_fault pulses, mem_badaddr = captured full address, mem_q_valid=0, state -> DONE.
  - If dbus_ack and dbus_err are both 1, err wins.
  - Stores: no mem_q_valid.
- BUSY & flush (without ack/err that cycle): state -> DRAIN. The bus transaction cannot be aborted, so dbus_req stays high.
- DRAIN:
  - Wait for ack/err, then go to IDLE.
  - Read data and errors are discarded; no strobes.
- DONE:
  - Lasts exactly one cycle; no accept, because EX still presents the completed instruction.
  - Next state is IDLE.
- Stall: dmem_stall = accept | (state==BUSY) | (state==DRAIN & ex_req & !ex_bubble). It is 0 in DONE.
- Latency with zero-wait ack (ack in the first BUSY cycle): accept cycle T, BUSY T+1, DONE T+2 (stall 0, result valid). The pipeline advances at the end of T+2. Throughput is one access per 3 cycles minimum.
- flush in IDLE blocks accept. flush in DONE suppresses nothing: the strobes are already registered, and the consumer qualifies them.
- Reset mid-transaction: immediately returns to IDLE and drops dbus_req. The bus is required to tolerate request withdrawal under reset.

Test Plan:
- LB from adr 0x103, dbus_q=0x80_00_00_00, zero-wait ack -> dbus_be=1000, dbus_adr=0x100; mem_q=0xFFFFFF80 and mem_q_valid at T+2; stall high at T and T+1 only.
- LHU from 0x202, dbus_q=0xBEEF_1234, ack after 3 wait cycles -> dbus_be=1100, mem_q=0x0000BEEF, dbus_req held stable 4 cycles.
- SB at 0x101 with ex_d=0x5A -> dbus_we=1, dbus_be=0010, dbus_d=0x5A5A5A5A, no mem_q_valid.
- LW at 0x302 -> no dbus_req; ma_load=1 for one cycle with mem_badaddr=0x302. SH at 0x301 -> ma_store=1, mem_badaddr=0x301.
- LW at 0x400 with dbus_err and dbus_ack both asserted -> ac_fault pulse, mem_badaddr=0x400, mem_q_valid=0.
- LW in BUSY with flush, then new ex_req presented, ack after 2 cycles -> state DRAIN, data discarded, stall high until ack, new request accepted the cycle after returning to IDLE. Also assert rstn low during BUSY -> dbus_req=0 immediately.

Source files
------------

// File: rtl/riscv_dmem_ctrl.sv
// rtl/riscv_dmem_ctrl.sv - EX-to-data-bus load/store sequencer with alignment, extension and exceptions
module riscv_dmem_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            ex_req,
    input  logic            ex_bubble,
    input  logic            ex_we,
    input  logic [2:0]      ex_size,
    input  logic [XLEN-1:0] ex_adr,
    input  logic [XLEN-1:0] ex_d,
    output logic            dmem_stall,
    output logic [XLEN-1:0] mem_q,
    output logic            mem_q_valid,
    output logic            ma_load,
    output logic            ma_store,
    output logic            ac_fault,
    output logic [XLEN-1:0] mem_badaddr,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_adr,
    output logic [3:0]      dbus_be,
    output logic [XLEN-1:0] dbus_d,
    input  logic            dbus_ack,
    input  logic            dbus_err,
    input  logic [XLEN-1:0] dbus_q
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("riscv_dmem_ctrl: only XLEN=32 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Size/offset of the access in flight, kept for load alignment and fault address
    logic [2:0] cap_size;
    logic [1:0] cap_k;

    logic ex_valid;
    logic accept;
    logic misaligned;
    logic bus_done;

    // Decoded actions for the registered-output process
    logic issue;
    logic ma_hit;
    logic complete;
    logic fault;
    logic release_bus;

    logic [3:0]      be_nxt;
    logic [XLEN-1:0] d_nxt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] q_ext;

    assign ex_valid = ex_req & ~ex_bubble;
    assign accept   = (state == IDLE) & ex_valid & ~flush;
    assign bus_done = dbus_ack | dbus_err;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault
    assign misaligned = ((ex_size[1:0] == 2'b01) & ex_adr[0]) |
                        (ex_size[1] & (ex_adr[1:0] != 2'b00));

    assign dmem_stall = accept | (state == BUSY) | ((state == DRAIN) & ex_valid);

    // Byte-lane enables and store-data replication from size and low address bits
    always_comb begin
        be_nxt = 4'b1111;
        d_nxt  = ex_d;
        case (ex_size[1:0])
            2'b00: begin
                be_nxt = 4'b0001 << ex_adr[1:0];
                d_nxt  = {4{ex_d[7:0]}};
            end
            2'b01: begin
                be_nxt = 4'b0011 << ex_adr[1:0];
                d_nxt  = {2{ex_d[15:0]}};
            end
            default: begin
                be_nxt = 4'b1111;
                d_nxt  = ex_d;
            end
        endcase
    end

    // Shift the addressed lane down and sign- or zero-extend it to XLEN
    always_comb begin
        shifted = dbus_q >> {cap_k, 3'b000};
        q_ext   = shifted;
        case (cap_size)
            3'b000:  q_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  q_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  q_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  q_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: q_ext = shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and action decode; an error beats a simultaneous ack, and ack beats flush
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        ma_hit      = 1'b0;
        complete    = 1'b0;
        fault       = 1'b0;
        release_bus = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        ma_hit    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dbus_err) begin
                    fault       = 1'b1;
                    release_bus = 1'b1;
                    state_nxt   = DONE;
                end else if (dbus_ack) begin
                    complete    = 1'b1;
                    release_bus = 1'b1;
                    state_nxt   = DONE;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus_done) begin
                    release_bus = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus request and its attributes; attributes stay frozen until the next issue
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            dbus_adr <= '0;
            dbus_be  <= 4'b0000;
            dbus_d   <= '0;
            cap_size <= 3'b000;
            cap_k    <= 2'b00;
        end else if (issue) begin
            dbus_req <= 1'b1;
            dbus_we  <= ex_we;
            dbus_adr <= {ex_adr[XLEN-1:2], 2'b00};
            dbus_be  <= be_nxt;
            dbus_d   <= d_nxt;
            cap_size <= ex_size;
            cap_k    <= ex_adr[1:0];
        end else if (release_bus) begin
            dbus_req <= 1'b0;
        end
    end

    // One-cycle result and exception strobes, plus the held load result and fault address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q       <= '0;
            mem_q_valid <= 1'b0;
            ma_load     <= 1'b0;
            ma_store    <= 1'b0;
            ac_fault    <= 1'b0;
            mem_badaddr <= '0;
        end else begin
            mem_q_valid <= complete & ~dbus_we;
            ma_load     <= ma_hit & ~ex_we;
            ma_store    <= ma_hit & ex_we;
            ac_fault    <= fault;
            if (complete & ~dbus_we) begin
                mem_q <= q_ext;
            end
            if (ma_hit) begin
                mem_badaddr <= ex_adr;
            end else if (fault) begin
                mem_badaddr <= {dbus_adr[XLEN-1:2], cap_k};
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// tb/tb_riscv_dmem_ctrl.sv - self-checking bench for riscv_dmem_ctrl
module tb_riscv_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        ex_req = 1'b0;
    logic        ex_bubble = 1'b0;
    logic        ex_we = 1'b0;
    logic [2:0]  ex_size = 3'b010;
    logic [31:0] ex_adr = '0;
    logic [31:0] ex_d = '0;
    logic        dmem_stall;
    logic [31:0] mem_q;
    logic        mem_q_valid;
    logic        ma_load;
    logic        ma_store;
    logic        ac_fault;
    logic [31:0] mem_badaddr;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_adr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_d;
    logic        dbus_ack = 1'b0;
    logic        dbus_err = 1'b0;
    logic [31:0] dbus_q = '0;

    int tests_run = 0;
    int tests_failed = 0;

    riscv_dmem_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .ex_req(ex_req), .ex_bubble(ex_bubble), .ex_we(ex_we),
        .ex_size(ex_size), .ex_adr(ex_adr), .ex_d(ex_d),
        .dmem_stall(dmem_stall), .mem_q(mem_q), .mem_q_valid(mem_q_valid),
        .ma_load(ma_load), .ma_store(ma_store), .ac_fault(ac_fault),
        .mem_badaddr(mem_badaddr), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_adr(dbus_adr), .dbus_be(dbus_be), .dbus_d(dbus_d),
        .dbus_ack(dbus_ack), .dbus_err(dbus_err), .dbus_q(dbus_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase = 0;   // 0 idle, 1 bus owned, 2 draining flushed access, 3 result cycle
    bit          m_req = 0, m_we = 0, m_qv = 0, m_mal = 0, m_mas = 0, m_af = 0;
    logic [31:0] m_adr = 0, m_d = 0, m_q = 0, m_bad = 0;
    logic [3:0]  m_be = 0;
    int          m_k = 0, m_nb = 4;
    bit          m_signed = 0;

    function automatic int nbytes(input logic [2:0] sz);
        if (sz[1:0] == 2'b00) return 1;
        if (sz[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] q, input int k, input int nb, input bit sgn);
        longint v;
        longint span;
        v = longint'(q) / (longint'(1) << (8 * k));
        if (nb < 4) begin
            span = longint'(1) << (8 * nb);
            v = v % span;
            if (sgn && v >= span / 2) v = v - span;
        end
        return v[31:0];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase = 0; m_req = 0; m_we = 0; m_qv = 0; m_mal = 0; m_mas = 0; m_af = 0;
            m_adr = 0; m_d = 0; m_q = 0; m_bad = 0; m_be = 0;
        end else begin
            m_qv = 0; m_mal = 0; m_mas = 0; m_af = 0;
            case (m_phase)
                0: if (ex_req && !ex_bubble && !flush) begin
                    m_nb = nbytes(ex_size);
                    m_k  = int'(ex_adr % 4);
                    if (ex_adr % m_nb != 0) begin
                        if (ex_we) m_mas = 1; else m_mal = 1;
                        m_bad   = ex_adr;
                        m_phase = 3;
                    end else begin
                        m_req    = 1;
                        m_we     = ex_we;
                        m_adr    = ex_adr - m_k;
                        m_be     = 4'(((1 << m_nb) - 1) << m_k);
                        m_d      = (m_nb == 1) ? (ex_d % 256) * 32'h01010101 :
                                   (m_nb == 2) ? (ex_d % 65536) * 32'h00010001 : ex_d;
                        m_signed = (ex_size[2] == 1'b0);
                        m_phase  = 1;
                    end
                end
                1: if (dbus_err) begin
                    m_af = 1; m_bad = m_adr + m_k; m_req = 0; m_phase = 3;
                end else if (dbus_ack) begin
                    m_req = 0; m_phase = 3;
                    if (!m_we) begin
                        m_q  = extend(dbus_q, m_k, m_nb, m_signed);
                        m_qv = 1;
                    end
                end else if (flush) begin
                    m_phase = 2;
                end
                2: if (dbus_ack || dbus_err) begin
                    m_req = 0; m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("stall", dmem_stall,
                (m_phase == 0 && rstn && ex_req && !ex_bubble && !flush) || m_phase == 1 ||
                (m_phase == 2 && ex_req && !ex_bubble));
            chk("dbus_req", dbus_req, m_req);
            chk("dbus_we", dbus_we, m_we);
            chk("dbus_adr", dbus_adr, m_adr);
            chk("dbus_be", dbus_be, m_be);
            chk("dbus_d", dbus_d, m_d);
            chk("mem_q", mem_q, m_q);
            chk("mem_q_valid", mem_q_valid, m_qv);
            chk("ma_load", ma_load, m_mal);
            chk("ma_store", ma_store, m_mas);
            chk("ac_fault", ac_fault, m_af);
            chk("mem_badaddr", mem_badaddr, m_bad);
        end
    end

    // ---------------- directed access ----------------
    logic        r_stall_t, r_stall_busy, r_stall_done, r_req_any, r_stable;
    logic        r_we, r_qv, r_mal, r_mas, r_af;
    logic [31:0] r_adr, r_d, r_q, r_bad;
    logic [3:0]  r_be;
    int          r_req_cycles;

    task automatic access(input bit we, input logic [2:0] size, input logic [31:0] adr,
                          input logic [31:0] d, input logic [31:0] q, input int waits,
                          input bit ack, input bit err);
        @(posedge clk); #1;
        ex_req = 1; ex_bubble = 0; ex_we = we; ex_size = size; ex_adr = adr; ex_d = d;
        @(negedge clk); r_stall_t = dmem_stall;
        @(posedge clk); #1;
        r_req_any = dbus_req; r_req_cycles = 0; r_stable = 1; r_stall_busy = 0;
        if (dbus_req) begin
            r_we = dbus_we; r_adr = dbus_adr; r_be = dbus_be; r_d = dbus_d;
            r_stall_busy = dmem_stall;
            for (int n = 0; n < waits; n++) begin
                @(negedge clk);
                r_req_cycles++;
                if (!dbus_req || dbus_adr !== r_adr || dbus_be !== r_be || dbus_d !== r_d) r_stable = 0;
                @(posedge clk); #1;
            end
            dbus_ack = ack; dbus_err = err; dbus_q = q;
            @(negedge clk);
            r_req_cycles++;
            if (!dbus_req || dbus_adr !== r_adr || dbus_be !== r_be || dbus_d !== r_d) r_stable = 0;
            r_stall_busy = r_stall_busy & dmem_stall;
            @(posedge clk); #1;
            dbus_ack = 0; dbus_err = 0;
        end
        @(negedge clk);
        r_q = mem_q; r_qv = mem_q_valid; r_mal = ma_load; r_mas = ma_store;
        r_af = ac_fault; r_bad = mem_badaddr; r_stall_done = dmem_stall;
        @(posedge clk); #1;
        ex_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req", dbus_req, 0);
        chk("reset_be", dbus_be, 0);
        chk("reset_mem_q", mem_q, 0);
        rstn = 1;
        repeat (2) @(posedge clk);

        // LB 0x103, zero-wait
        access(0, 3'b000, 32'h103, 0, 32'h8000_0000, 0, 1, 0);
        chk("lb_be", r_be, 4'b1000);
        chk("lb_adr", r_adr, 32'h100);
        chk("lb_q", r_q, 32'hFFFF_FF80);
        chk("lb_qv", r_qv, 1);
        chk("lb_stall_t", r_stall_t, 1);
        chk("lb_stall_busy", r_stall_busy, 1);
        chk("lb_stall_done", r_stall_done, 0);

        // LHU 0x202, 3 wait cycles
        access(0, 3'b101, 32'h202, 0, 32'hBEEF_1234, 3, 1, 0);
        chk("lhu_be", r_be, 4'b1100);
        chk("lhu_q", r_q, 32'h0000_BEEF);
        chk("lhu_req_cycles", r_req_cycles, 4);
        chk("lhu_stable", r_stable, 1);

        // SB 0x101
        access(1, 3'b000, 32'h101, 32'h5A, 0, 1, 1, 0);
        chk("sb_we", r_we, 1);
        chk("sb_be", r_be, 4'b0010);
        chk("sb_d", r_d, 32'h5A5A_5A5A);
        chk("sb_qv", r_qv, 0);

        // LH 0x002 sign extension, SH 0x002 replication, LBU 0x001, SW 0x10
        access(0, 3'b001, 32'h002, 0, 32'h8001_0000, 1, 1, 0);
        chk("lh_q", r_q, 32'hFFFF_8001);
        access(1, 3'b001, 32'h002, 32'hCAFE_1357, 0, 0, 1, 0);
        chk("sh_be", r_be, 4'b1100);
        chk("sh_d", r_d, 32'h1357_1357);
        access(0, 3'b100, 32'h001, 0, 32'h0000_F000, 0, 1, 0);
        chk("lbu_q", r_q, 32'h0000_00F0);
        access(1, 3'b010, 32'h010, 32'h1234_5678, 0, 2, 1, 0);
        chk("sw_be", r_be, 4'b1111);
        chk("sw_d", r_d, 32'h1234_5678);

        // Misaligned LW / SH
        access(0, 3'b010, 32'h302, 0, 0, 0, 1, 0);
        chk("malw_noreq", r_req_any, 0);
        chk("malw_strobe", r_mal, 1);
        chk("malw_bad", r_bad, 32'h302);
        access(1, 3'b001, 32'h301, 0, 0, 0, 1, 0);
        chk("mash_noreq", r_req_any, 0);
        chk("mash_strobe", r_mas, 1);
        chk("mash_bad", r_bad, 32'h301);

        // LW 0x400 with err and ack together
        access(0, 3'b010, 32'h400, 0, 32'h1111_1111, 0, 1, 1);
        chk("err_af", r_af, 1);
        chk("err_bad", r_bad, 32'h400);
        chk("err_qv", r_qv, 0);

        // Bubble and flush in IDLE block accept
        @(posedge clk); #1;
        ex_req = 1; ex_bubble = 1; ex_size = 3'b010; ex_adr = 32'h800;
        @(negedge clk); chk("bubble_stall", dmem_stall, 0);
        @(posedge clk); #1; chk("bubble_noreq", dbus_req, 0);
        ex_bubble = 0; flush = 1;
        @(negedge clk); chk("flush_idle_stall", dmem_stall, 0);
        @(posedge clk); #1; chk("flush_idle_noreq", dbus_req, 0);
        flush = 0; ex_req = 0;

        // Flush during BUSY, drain, then new access
        @(posedge clk); #1;
        ex_req = 1; ex_we = 0; ex_size = 3'b010; ex_adr = 32'h500;
        @(posedge clk); #1;
        chk("drain_busy_req", dbus_req, 1);
        flush = 1; ex_req = 0;
        @(posedge clk); #1;
        flush = 0; ex_adr = 32'h600; ex_req = 1; dbus_q = 32'hDEAD_BEEF;
        @(negedge clk); chk("drain_stall1", dmem_stall, 1);
        @(posedge clk); #1;
        dbus_ack = 1;
        @(negedge clk); chk("drain_stall2", dmem_stall, 1);
        @(posedge clk); #1;
        dbus_ack = 0;
        @(negedge clk);
        chk("drain_qv", mem_q_valid, 0);
        chk("drain_idle_req", dbus_req, 0);
        chk("drain_accept_stall", dmem_stall, 1);
        @(posedge clk); #1;
        chk("drain_new_req", dbus_req, 1);
        chk("drain_new_adr", dbus_adr, 32'h600);
        dbus_ack = 1; dbus_q = 32'h1122_3344;
        @(posedge clk); #1;
        dbus_ack = 0;
        @(negedge clk);
        chk("drain_new_q", mem_q, 32'h1122_3344);
        chk("drain_new_qv", mem_q_valid, 1);
        @(posedge clk); #1;
        ex_req = 0;

        // Reset during BUSY drops the request immediately
        @(posedge clk); #1;
        ex_req = 1; ex_size = 3'b010; ex_adr = 32'h700;
        @(posedge clk); #1;
        chk("rst_busy_req", dbus_req, 1);
        rstn = 0; ex_req = 0;
        #1;
        chk("rst_drop_req", dbus_req, 0);
        @(posedge clk); #1;
        rstn = 1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
